// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: decodes ALU-class RV32I opcodes into a registered
// output slot backed by a one-entry skid buffer, strictly preserving issue order.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            out_activate,
  output logic [2:0]      out_op,
  output logic [6:0]      out_subop,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  typedef struct packed {
    logic [2:0]      op;
    logic [6:0]      subop;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } entry_t;

  entry_t dec;
  entry_t slot_q, slot_d, skid_q, skid_d;
  logic   slot_valid_q, slot_valid_d, skid_valid_q, skid_valid_d;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  logic            legal, writes;
  logic            accept, slot_free;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_u  = {in_inst[31:12], {(XLEN-20){1'b0}}};

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    writes = 1'b0;
    dec.rd = in_inst[11:7];
    case (opcode)
      OpcOp: begin
        dec.op    = f3;
        dec.subop = f7;
        dec.op1   = in_rs1_data;
        dec.op2   = in_rs2_data;
        writes    = 1'b1;
        legal     = (f7 == F7Zero) || ((f7 == F7Alt) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OpcOpImm: begin
        dec.op  = f3;
        dec.op1 = in_rs1_data;
        dec.op2 = imm_i;
        writes  = 1'b1;
        // Only shifts carry a funct7; for everything else imm[11:5] is data, not a subop.
        if (f3 == 3'b101) begin
          dec.subop = f7;
          legal     = (f7 == F7Zero) || (f7 == F7Alt);
        end else if (f3 == 3'b001) begin
          legal = (f7 == F7Zero);
        end
      end
      OpcLui: begin
        dec.op2 = imm_u;
        writes  = 1'b1;
      end
      OpcAuipc: begin
        dec.op1 = in_pc;
        dec.op2 = imm_u;
        writes  = 1'b1;
      end
      OpcLoad: begin
        dec.op1 = in_rs1_data;
        dec.op2 = imm_i;
        writes  = 1'b1;
      end
      OpcStore: begin
        dec.op1 = in_rs1_data;
        dec.op2 = imm_s;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op    = '0;
      dec.subop = '0;
      dec.op1   = '0;
      dec.op2   = '0;
      writes    = 1'b0;
    end
    dec.illegal = !legal;
    dec.wen     = writes && (dec.rd != 5'd0);
  end

  assign in_ready  = !skid_valid_q && !RST;
  assign accept    = in_valid && in_ready && !flush;
  assign slot_free = !slot_valid_q || out_ready;

  always_comb begin
    slot_d       = slot_q;
    skid_d       = skid_q;
    slot_valid_d = slot_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free) begin
      // A full skid means in_ready was low, so no new beat competes for the slot.
      if (skid_valid_q) begin
        slot_d       = skid_q;
        slot_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        slot_d       = dec;
        slot_valid_d = 1'b1;
      end else begin
        slot_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_q       <= '0;
      skid_q       <= '0;
      slot_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      skid_q       <= skid_d;
      slot_valid_q <= slot_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = slot_valid_q;
  assign out_activate = slot_valid_q;
  assign out_op       = slot_q.op;
  assign out_subop    = slot_q.subop;
  assign out_op1      = slot_q.op1;
  assign out_op2      = slot_q.op2;
  assign out_rd       = slot_q.rd;
  assign out_wen      = slot_q.wen;
  assign out_illegal  = slot_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ISA cases, stall/flush/reset scenarios
// and randomized traffic checked against a behavioural decode model.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [2:0]  op;
    logic [6:0]  subop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_activate, out_wen, out_illegal;
  logic [2:0]  out_op;
  logic [6:0]  out_subop;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  logic rst_s = 1'b1;
  bit   rand_ready = 1'b0;
  bit   ready_fixed = 1'b0;

  alu_issue_stage #(.XLEN(32)) dut (
    .CLK         (clk),
    .RST         (RST),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_activate(out_activate),
    .out_op      (out_op),
    .out_subop   (out_subop),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_s <= RST;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic [6:0] subop,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] rd, input logic wen, input logic ill);
    exp_t e;
    e.op = op; e.subop = subop; e.op1 = op1; e.op2 = op2; e.rd = rd; e.wen = wen; e.ill = ill;
    return e;
  endfunction

  // Reference decode, straight from the instruction-set rules.
  function automatic exp_t ref_model(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t        e;
    logic [6:0]  opc   = inst[6:0];
    logic [2:0]  f3    = inst[14:12];
    logic [6:0]  f7    = inst[31:25];
    logic [11:0] i12   = inst[31:20];
    logic [11:0] s12   = {inst[31:25], inst[11:7]};
    logic [31:0] i_imm = 32'($signed(i12));
    logic [31:0] s_imm = 32'($signed(s12));
    logic [31:0] u_imm = inst & 32'hFFFF_F000;
    bit          legal = 1'b1;
    bit          writes = 1'b0;
    e = '0;
    e.rd = inst[11:7];
    case (opc)
      7'h33: begin
        e.op = f3; e.subop = f7; e.op1 = rs1; e.op2 = rs2; writes = 1'b1;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        e.op = f3; e.op1 = rs1; e.op2 = i_imm; writes = 1'b1;
        if (f3 == 3'd5) begin
          e.subop = f7;
          legal = (f7 == 7'h00) || (f7 == 7'h20);
        end else if (f3 == 3'd1) begin
          legal = (f7 == 7'h00);
        end
      end
      7'h37: begin e.op2 = u_imm; writes = 1'b1; end
      7'h17: begin e.op1 = pc; e.op2 = u_imm; writes = 1'b1; end
      7'h03: begin e.op1 = rs1; e.op2 = i_imm; writes = 1'b1; end
      7'h23: begin e.op1 = rs1; e.op2 = s_imm; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.op = '0; e.subop = '0; e.op1 = '0; e.op2 = '0; writes = 1'b0;
    end
    e.ill = !legal;
    e.wen = writes && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic set_beat(input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
    in_inst = inst; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    cur_exp = e;
    in_valid = 1'b1;
  endtask

  // Returns at posedge+1 with in_valid low; the expected entry is queued on acceptance.
  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (in_ready && !flush && !RST) begin
        exp_q.push_back(cur_exp);
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
    set_beat(inst, pc, rs1, rs2, e);
    wait_accept();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer_rand();
    logic [31:0] inst, pc, rs1, rs2;
    logic [6:0]  opcs[7];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h00};
    inst = $urandom;
    k = $urandom_range(0, 6);
    inst[6:0] = (k == 6) ? 7'($urandom) : opcs[k];
    case ($urandom_range(0, 3))
      0: inst[31:25] = 7'h00;
      1: inst[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) inst[11:7] = 5'd0;
    pc = $urandom; rs1 = $urandom; rs2 = $urandom;
    offer(inst, pc, rs1, rs2, ref_model(inst, pc, rs1, rs2));
  endtask

  // out_ready changes at posedge+2 so directed settings made at posedge+1 apply the same cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Monitor: compare whatever the slot presents against the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op1", out_op1, 32'd0);
        check("rst_op2", out_op2, 32'd0);
        check("rst_misc", 32'({out_activate, out_op, out_subop, out_rd, out_wen, out_illegal}), 0);
        check("rst_in_ready", 32'(in_ready), 32'(!RST));
      end else begin
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_activate", 32'(out_activate), 32'(out_valid));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 && !RST));
        if (out_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          check("op", 32'(out_op), 32'(e.op));
          check("subop", 32'(out_subop), 32'(e.subop));
          check("op1", out_op1, e.op1);
          check("op2", out_op2, e.op2);
          check("wen", 32'(out_wen), 32'(e.wen));
          check("illegal", 32'(out_illegal), 32'(e.ill));
          if (!e.ill) check("rd", 32'(out_rd), 32'(e.rd));
        end
      end
      if (RST || flush) exp_q.delete();
      else if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    RST = 1'b0;
    ready_fixed = 1'b1;

    offer(32'hFFF08293, 32'h0, 32'h10, 32'h0, mk(3'b000, 7'h00, 32'h10, 32'hFFFF_FFFF, 5'd5, 1, 0));
    offer(32'h40008293, 32'h0, 32'h77, 32'h0, mk(3'b000, 7'h00, 32'h77, 32'h400, 5'd5, 1, 0));
    offer(32'h4030D293, 32'h0, 32'h8000_0000, 32'h0,
          mk(3'b101, 7'h20, 32'h8000_0000, 32'h403, 5'd5, 1, 0));
    offer(32'h402081B3, 32'h0, 32'd9, 32'd4, mk(3'b000, 7'h20, 32'd9, 32'd4, 5'd3, 1, 0));
    offer(32'h123453B7, 32'h0, 32'h55, 32'h66, mk(3'b000, 7'h00, 32'h0, 32'h1234_5000, 5'd7, 1, 0));
    offer(32'h12345397, 32'h100, 32'h55, 32'h66,
          mk(3'b000, 7'h00, 32'h100, 32'h1234_5000, 5'd7, 1, 0));
    offer(32'h00208033, 32'h0, 32'h3, 32'h5, mk(3'b000, 7'h00, 32'h3, 32'h5, 5'd0, 0, 0));
    offer(32'h00000073, 32'h0, 32'h3, 32'h5, mk(3'b000, 7'h00, 32'h0, 32'h0, 5'd0, 0, 1));
    cycles(3);

    // Stall: A held in slot, B in skid, C must wait until both drain.
    ready_fixed = 1'b0;
    cycles(1);
    offer(32'h00108133, 32'h0, 32'hA, 32'h1, mk(3'b000, 7'h00, 32'hA, 32'h1, 5'd2, 1, 0));
    offer(32'h00108133, 32'h0, 32'hB, 32'h2, mk(3'b000, 7'h00, 32'hB, 32'h2, 5'd2, 1, 0));
    set_beat(32'h00108133, 32'h0, 32'hC, 32'h3, mk(3'b000, 7'h00, 32'hC, 32'h3, 5'd2, 1, 0));
    cycles(3);
    ready_fixed = 1'b1;
    wait_accept();
    cycles(4);

    // Flush with both entries full and a beat on offer; that beat must never emerge.
    ready_fixed = 1'b0;
    cycles(1);
    offer(32'h00108133, 32'h0, 32'h1A, 32'h1, mk(3'b000, 7'h00, 32'h1A, 32'h1, 5'd2, 1, 0));
    offer(32'h00108133, 32'h0, 32'h1B, 32'h2, mk(3'b000, 7'h00, 32'h1B, 32'h2, 5'd2, 1, 0));
    set_beat(32'h00108133, 32'h0, 32'h1D, 32'h4, mk(3'b000, 7'h00, 32'h1D, 32'h4, 5'd2, 1, 0));
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    in_valid = 1'b0;
    ready_fixed = 1'b1;
    cycles(3);

    // Reset in the middle of a stall.
    ready_fixed = 1'b0;
    cycles(1);
    offer(32'h00108133, 32'h0, 32'h2A, 32'h1, mk(3'b000, 7'h00, 32'h2A, 32'h1, 5'd2, 1, 0));
    offer(32'h00108133, 32'h0, 32'h2B, 32'h2, mk(3'b000, 7'h00, 32'h2B, 32'h2, 5'd2, 1, 0));
    RST = 1'b1;
    cycles(3);
    RST = 1'b0;
    ready_fixed = 1'b1;
    cycles(3);

    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      cycles($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) begin
        set_beat(32'h00000013, 32'h0, 32'h0, 32'h0, '0);
        in_valid = 1'($urandom_range(0, 1));
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        in_valid = 1'b0;
      end
      offer_rand();
    end

    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycles(1);
    cycles(2);
    check("drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU in the multi-cycle RV32I core.
- Accepts a fetched instruction, its PC and register-file read data over a valid/ready handshake.
- Decodes the ALU-class opcodes, builds immediates and drives the ALU's activate/op/subop/op1/op2 inputs from a registered output slot backed by a one-entry skid buffer.
- Carries rd and write-enable forward to writeback.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, synchronous, active-high.
flush  in  1  synchronous kill of all buffered entries.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  stage can accept this cycle.
in_inst  in  32  instruction word.
in_pc  in  32  PC of in_inst.
in_rs1_data  in  32  register-file value for rs1.
in_rs2_data  in  32  register-file value for rs2.
out_ready  in  1  consumer takes the output slot.
out_valid  out  1  output slot holds an instruction.
out_activate  out  1  ALU activate; equals out_valid.
out_op  out  3  ALU op (funct3-style).
out_subop  out  7  ALU subop (funct7-style).
out_op1  out  32  ALU operand 1.
out_op2  out  32  ALU operand 2.
out_rd  out  5  destination register.
out_wen  out  1  register write enable.
out_illegal  out  1  unsupported or malformed encoding.

Behaviour:
- Reset: while RST is high, all outputs are 0 and in_ready is 0. Both entries are empty; in_ready is 1 in the first cycle after RST deasserts.
- Latency: a beat accepted at edge N (in_valid & in_ready) appears on out_* after edge N when the slot is free. Decode is registered; there are no combinational in->out paths.
- Handshake: an output is consumed on out_valid & out_ready. While out_valid & !out_ready, all out_* are held stable.
- in_ready = !skid_valid (registered source).
- Routing of an accepted beat:
  - Output slot empty, or draining in the same cycle, with skid empty: beat goes straight to the output slot.
  - Otherwise: beat goes to the skid entry.
- When the slot drains and skid is full, the skid entry moves to the slot and skid empties. in_ready was 0 that cycle, so no new beat is accepted.
- Order is strictly preserved; no beat is lost or duplicated.
- flush: next cycle both entries are empty, out_valid=0 and in_ready=1. A beat offered in the flush cycle is dropped. flush overrides out_ready.
- Decode (f3=inst[14:12], f7=inst[31:25], rd=inst[11:7]):
  - OP 0110011: op=f3, subop=f7, op1=rs1, op2=rs2. Illegal if f7 is not 0000000/0100000, or f7=0100000 with f3 not in {000,101}.
  - OP-IMM 0010011: op=f3, op1=rs1, op2=sext(inst[31:20]). Subop by f3:
    - f3=101: subop=f7; illegal unless f7 is 0000000/0100000.
    - f3=001: subop=0; illegal unless f7=0000000.
    - All other f3: subop=0000000, so ADDI is never issued as SUB whatever the imm bits.
  - LUI 0110111: op=000, subop=0, op1=0, op2={inst[31:12],12'b0}.
  - AUIPC 0010111: as LUI but op1=pc.
  - LOAD 0000011: op=000, subop=0, op1=rs1, op2=I-imm, wen=1.
  - STORE 0100011: op=000, subop=0, op1=rs1, op2=sext({inst[31:25],inst[11:7]}), wen=0.
  - Any other opcode: out_illegal=1.
- Illegal beats are still issued (out_valid=1) with op=000, subop=0, op1=op2=0, wen=0.
- out_wen=1 for OP/OP-IMM/LUI/AUIPC/LOAD, forced to 0 when rd=0 or the beat is illegal.
- All arithmetic is modulo 2^32; sign extension is from the immediate MSB.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1=0x10 -> next cycle: out_valid=1, op=000, subop=0000000, op1=0x10, op2=0xFFFFFFFF, rd=5, wen=1.
- ADDI 0x40008293 -> subop=0000000 (not SUB), op2=0x00000400.
- SRAI x5,x1,3 (0x4030D293) -> op=101, subop=0100000, op2=0x403.
- SUB x3,x1,x2 (0x402081B3), rs1=9, rs2=4 -> subop=0100000, op1=9, op2=4.
- LUI x7 (0x123453B7) -> op1=0, op2=0x12345000.
- AUIPC x7 (0x12345397), pc=0x100 -> op1=0x100, op2=0x12345000.
- ADD with rd=0 -> wen=0.
- out_ready=0; push A, B -> A held, B in skid, in_ready=0, C stalls. Raise out_ready -> A, B, C emerge on consecutive accepts, in order, no duplicates.
- ECALL 0x00000073 -> out_illegal=1, wen=0, op1=op2=0, out_valid=1.
- flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, offered beat never appears.
- RST asserted mid-stall -> all outputs 0 while RST is high; in_ready=1 one cycle after release.
